// File: rtl/arith_pkg.sv
// Shared constants for the pipelined arithmetic unit: default width and Sel encodings.
// No logic; imported by arith_core and arith_unit_pipe.
// Sel picks the second adder operand: B, ~B, all-zeros or all-ones.
package arith_pkg;

   localparam int ARITH_WIDTH = 8;

   typedef enum logic [1:0] {
      SEL_ADD = 2'b00,   // A + B + cin
      SEL_SUB = 2'b01,   // A + ~B + cin
      SEL_INC = 2'b10,   // A + cin
      SEL_DEC = 2'b11    // A + all-ones + cin
   } sel_e;

endpackage

// File: rtl/arith_core.sv
// Combinational operand mux plus WIDTH+1-bit adder with raw carry and signed overflow.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline qualifies when results are captured.
// Ports: a, b (operands), cin, sel -> sum (WIDTH bits), carry (sum MSB), v_raw (signed overflow).
module arith_core
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             v_raw
);

   logic [WIDTH-1:0] m;
   logic [WIDTH:0]   sum_full;

   always_comb begin
      m = b;
      case (sel_e'(sel))
         SEL_ADD: m = b;
         SEL_SUB: m = ~b;
         SEL_INC: m = '0;
         SEL_DEC: m = '1;
         default: m = b;
      endcase
   end

   assign sum_full = {1'b0, a} + {1'b0, m} + {{WIDTH{1'b0}}, cin};
   assign sum      = sum_full[WIDTH-1:0];
   assign carry    = sum_full[WIDTH];
   // Overflow: both addends share a sign and the result sign differs from it.
   assign v_raw    = (a[WIDTH-1] == m[WIDTH-1]) && (sum_full[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/arith_unit_pipe.sv
// Two-stage pipelined add/sub/inc/dec with registered flags and a stored carry for chained ops.
// Latency: 2 cycles from acceptance to out_valid; 1 op/cycle while out_ready is high.
// Backpressure: global stall when out_valid && !out_ready; in_ready drops combinationally, both stages hold.
// Ports: clk, rst (async, active-high); in_valid/in_ready, A, B, Ci, Sel, chain in;
//        out_valid/out_ready, D, Co, Z, N, V out.
// Optional macro ARITH_SAT_EN: clamp D to the signed extreme on overflow (otherwise D wraps).
module arith_unit_pipe
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
   input  logic [1:0]       Sel,
   input  logic             chain,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Co,
   output logic             Z,
   output logic             N,
   output logic             V
);

   logic             en;
   logic             accept;
   logic             cin;
   logic [WIDTH-1:0] sum_w;
   logic             carry_w;
   logic             v_raw_w;
   logic [WIDTH-1:0] d_fin;

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_sum_q,   s1_sum_d;
   logic             s1_carry_q, s1_carry_d;
   logic             s1_v_q,     s1_v_d;
   logic             carry_q,    carry_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] d_q,  d_d;
   logic             co_q, co_d;
   logic             v_q,  v_d;
   logic             z_q,  z_d;
   logic             n_q,  n_d;

   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;
   assign accept   = in_valid && en;
   assign cin      = chain ? carry_q : Ci;

   arith_core #(.WIDTH(WIDTH)) u_core (
      .a     (A),
      .b     (B),
      .cin   (cin),
      .sel   (Sel),
      .sum   (sum_w),
      .carry (carry_w),
      .v_raw (v_raw_w)
   );

   // Final result as presented at S2.
   always_comb begin
      d_fin = s1_sum_q;
`ifdef ARITH_SAT_EN
      // On overflow the wrapped sum sign is the opposite of A's sign, so a
      // negative wrapped sum means a positive overflow and vice versa.
      if (s1_v_q) begin
         if (s1_sum_q[WIDTH-1]) begin
            d_fin = {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            d_fin = {1'b1, {(WIDTH-1){1'b0}}};
         end
      end
`endif
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sum_d    = s1_sum_q;
      s1_carry_d  = s1_carry_q;
      s1_v_d      = s1_v_q;
      carry_d     = carry_q;
      out_valid_d = out_valid_q;
      d_d         = d_q;
      co_d        = co_q;
      v_d         = v_q;
      z_d         = z_q;
      n_d         = n_q;

      // Stored carry only moves on a completed handshake, so stalled or
      // idle cycles cannot corrupt a pending chain.
      if (accept) begin
         carry_d = carry_w;
      end

      if (en) begin
         s1_valid_d  = in_valid;
         if (in_valid) begin
            s1_sum_d   = sum_w;
            s1_carry_d = carry_w;
            s1_v_d     = v_raw_w;
         end
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            d_d  = d_fin;
            co_d = s1_carry_q;
            v_d  = s1_v_q;
            z_d  = (d_fin == '0);
            n_d  = d_fin[WIDTH-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sum_q    <= '0;
         s1_carry_q  <= 1'b0;
         s1_v_q      <= 1'b0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         d_q         <= '0;
         co_q        <= 1'b0;
         v_q         <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sum_q    <= s1_sum_d;
         s1_carry_q  <= s1_carry_d;
         s1_v_q      <= s1_v_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
         d_q         <= d_d;
         co_q        <= co_d;
         v_q         <= v_d;
         z_q         <= z_d;
         n_q         <= n_d;
      end
   end

   assign out_valid = out_valid_q;
   assign D         = d_q;
   assign Co        = co_q;
   assign Z         = z_q;
   assign N         = n_q;
   assign V         = v_q;

endmodule

// File: doc/arith_unit_pipe.md
# arith_unit_pipe

Parametrised, pipelined successor of the 4-bit Mano arithmetic circuit: WIDTH-bit operand-select-and-add with the same four Sel modes, plus registered status flags, a valid/ready handshake on both sides, and a stored carry for multi-word (chained) arithmetic. It sits between the register file read ports and the result bus of the ALU datapath.

## Interface
- WIDTH, 8, operand/result width; legal range is 2 or more.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Ci  in  1  external carry-in
- Sel  in  2  mode; 00 A+B+cin, 01 A+~B+cin, 10 A+cin, 11 A+all-ones+cin
- chain  in  1  1 = cin is the stored carry, 0 = cin is Ci
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- D  out  WIDTH  result
- Co  out  1  carry out of MSB
- Z  out  1  D == 0
- N  out  1  D[WIDTH-1]
- V  out  1  signed overflow

## Operation
- The operand mux selects M: B, ~B, all-zeros or all-ones per Sel. The sum is A + M + cin at WIDTH+1 bits, and its MSB is the raw carry.
- Raw V is (A[msb] == M[msb]) && (sum[msb] != A[msb]).
- Stage 1 (S1) registers sum[WIDTH-1:0], raw carry, raw V and s1_valid.
- Stage 2 (S2) registers D, Co, V, Z, N and out_valid. Z and N are derived from the final D.
- Stored carry carry_q:
  - Loads raw carry on every accepted op, whether or not chain is set.
  - Holds otherwise.
  - A chained op immediately following its predecessor sees that predecessor's carry, so there is no hazard.
- Global enable en = !out_valid || out_ready.
  - in_ready = en.
  - S1 and S2 advance only when en is high. S1 loads in_valid && en.
- Ordering is strict FIFO and no op is dropped or duplicated.
- An op whose handshake has not completed, either because in_valid is low or because of a stall, does not touch carry_q.

## Timing
- Latency is 2 cycles from acceptance (in_valid && in_ready) to out_valid, with no stall.
- Throughput is 1 op per cycle while out_ready is held high.
- On a stall (out_valid && !out_ready), S1 and S2 hold and in_ready drops in the same cycle (combinational from out_valid and out_ready).
  - The pipeline holds at most 2 ops.
- On transfer with a new op accepted in the same cycle, both stages shift and there is no bubble.
- D, Co, Z, N and V are stable while out_valid && !out_ready.
- Reset values: out_valid=0, D=0, Co=0, Z=0, N=0, V=0, s1_valid=0, carry_q=0.
  - in_ready=1 in reset and after it.
- Reset mid-operation discards all in-flight ops and clears carry_q.
  - The first op after reset with chain=1 uses cin=0.

## Configuration
- ARITH_SAT_EN defined: in S2, an op with V=1 clamps D to the signed extreme. This is 0111…1 when A[msb]=0, and 1000…0 when A[msb]=1.
  - V stays 1.
  - Co and carry_q are unaffected, since they come from the raw sum.
  - Z and N reflect the clamped D.
- ARITH_SAT_EN undefined: D wraps; no clamp logic is present.

## Structure
- Package arith_pkg holds:
  - Sel encodings SEL_ADD=2'b00, SEL_SUB=2'b01, SEL_INC=2'b10, SEL_DEC=2'b11.
  - The default WIDTH constant.
- Sub-module arith_core: the combinational operand mux and the WIDTH+1-bit adder. Inputs are A, B, cin and Sel; outputs are sum, carry and raw V.
- arith_unit_pipe holds the pipeline registers, carry_q, the handshake and the saturation logic.

## Test plan
- ADD signed overflow, WIDTH=8: Sel=00, A=0x7F, B=0x01, Ci=0.
  - Without the macro: D=0x80, Co=0, V=1, N=1, Z=0.
  - With ARITH_SAT_EN: D=0x7F, V=1, N=0.
- SUB equal: Sel=01, A=0x05, B=0x05, Ci=1 → D=0x00, Co=1, Z=1, V=0, out_valid exactly 2 cycles after acceptance.
- INC/DEC wrap:
  - Sel=10, A=0xFF, Ci=1 → D=0x00, Co=1, Z=1.
  - Sel=11, A=0x00, Ci=0 → D=0xFF, Co=0, N=1.
- Chained 16-bit add, 0x01FF+0x0001, issued back-to-back:
  - Low op (A=0xFF, B=0x01, chain=0) → D=0x00, Co=1.
  - High op (A=0x01, B=0x00, chain=1) → D=0x02, Co=0.
- Backpressure: stream 4 ops (A=1..4, B=0, Sel=00) with out_ready=0 for 3 cycles.
  - in_ready=0 once 2 ops are held.
  - D sequence 1,2,3,4 with no loss or repeat.
- Reset mid-flight: assert rst with 2 ops in flight.
  - All outputs are zero and out_valid=0 on the next edge.
  - After release, a chain=1 op with A=0x10, B=0x00 gives D=0x10.
